// File: rtl/axi_slave_arbiter.sv
// ---------------------------------------------------------------------------
// axi_slave_arbiter : per-slave round-robin arbiter with registered grant and
// lock held from grant until the final response handshake.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module axi_slave_arbiter #(
  parameter int NUM_M = 3,
  localparam int IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  input  logic [NUM_M-1:0] REQ,
  input  logic             ADDR_HS,
  input  logic             DONE,
  output logic [NUM_M-1:0] GRANT,
  output logic [IDX_W-1:0] GRANT_IDX,
  output logic             BUSY,
  output logic             ADDR_PEND
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_M-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;

  logic               found;
  logic [IDX_W-1:0]   win;
  logic [IDX_W:0]     sum;
  logic [IDX_W-1:0]   cand;

  // Scan masters starting at rr_ptr, wrapping modulo NUM_M; first requester wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_M; k++) begin
      sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_M)) begin
        sum = sum - (IDX_W+1)'(NUM_M);
      end
      cand = sum[IDX_W-1:0];
      if (!found && REQ[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    idx_d    = idx_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d  = S_ADDR;
          grant_d  = NUM_M'(1) << win;
          idx_d    = win;
          rr_ptr_d = (win == IDX_W'(NUM_M - 1)) ? '0 : win + 1'b1;
        end
      end
      S_ADDR: begin
        if (ADDR_HS) begin
          if (DONE) begin
            state_d = S_IDLE;
            grant_d = '0;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (DONE) begin
          state_d = S_IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      idx_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      idx_q    <= idx_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign GRANT     = grant_q;
  assign GRANT_IDX = idx_q;
  assign BUSY      = (state_q != S_IDLE);
  assign ADDR_PEND = (state_q == S_ADDR);

endmodule

`default_nettype wire

// File: tb/tb_axi_slave_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi_slave_arbiter : vector table, directed corner sequences and random
// traffic against a transaction-level reference model.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_axi_slave_arbiter;

  localparam int N  = 3;
  localparam int IW = 2;

  logic          ACLK;
  logic          ARESETn;
  logic [N-1:0]  REQ;
  logic          ADDR_HS;
  logic          DONE;
  logic [N-1:0]  GRANT;
  logic [IW-1:0] GRANT_IDX;
  logic          BUSY;
  logic          ADDR_PEND;

  axi_slave_arbiter #(.NUM_M(N)) dut (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .REQ       (REQ),
    .ADDR_HS   (ADDR_HS),
    .DONE      (DONE),
    .GRANT     (GRANT),
    .GRANT_IDX (GRANT_IDX),
    .BUSY      (BUSY),
    .ADDR_PEND (ADDR_PEND)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int nerr = 0;
  int nchk = 0;

  // Reference model: who owns the slave, whether the address is still
  // outstanding, and which master is first in line next time.
  int m_owner;
  bit m_pend;
  int m_rr;
  int m_idx;

  task automatic model_reset();
    m_owner = -1;
    m_pend  = 1'b0;
    m_rr    = 0;
    m_idx   = 0;
  endtask

  task automatic model_edge(input logic [N-1:0] r, input logic hs, input logic d);
    if (m_owner < 0) begin
      if (r != '0) begin
        for (int k = 0; k < N; k++) begin
          if (r[(m_rr + k) % N]) begin
            m_owner = (m_rr + k) % N;
            break;
          end
        end
        m_idx  = m_owner;
        m_pend = 1'b1;
        m_rr   = (m_owner + 1) % N;
      end
    end else if (m_pend) begin
      if (hs) begin
        if (d) m_owner = -1;
        else   m_pend  = 1'b0;
      end
    end else if (d) begin
      m_owner = -1;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string name);
    int eg;
    eg = (m_owner < 0) ? 0 : (1 << m_owner);
    chk({name, ".grant"}, int'(GRANT), eg);
    chk({name, ".idx"},   int'(GRANT_IDX), m_idx);
    chk({name, ".busy"},  int'(BUSY), (m_owner >= 0) ? 1 : 0);
    chk({name, ".pend"},  int'(ADDR_PEND), (m_owner >= 0 && m_pend) ? 1 : 0);
    chk({name, ".onehot"}, int'($onehot0(GRANT)), 1);
  endtask

  // Apply inputs for one cycle, advance the model across the edge, compare.
  task automatic step(input string name, input logic [N-1:0] r, input logic hs, input logic d);
    REQ     = r;
    ADDR_HS = hs;
    DONE    = d;
    @(posedge ACLK);
    model_edge(r, hs, d);
    #1;
    chk_model(name);
  endtask

  task automatic do_reset();
    ARESETn = 1'b0;
    REQ     = '0;
    ADDR_HS = 1'b0;
    DONE    = 1'b0;
    model_reset();
    repeat (2) @(posedge ACLK);
    #1;
    chk_model("reset");
    ARESETn = 1'b1;
  endtask

  typedef struct {
    logic [N-1:0]  req;
    logic          hs;
    logic          done;
    logic [N-1:0]  grant;
    logic [IW-1:0] idx;
    logic          busy;
    logic          pend;
  } vec_t;

  vec_t tbl[11];

  logic [N-1:0] rq;
  int           waitc[N];
  int           prev_owner;

  initial begin
    // Basic grant/handshake, combined HS+DONE in ADDR, idle rr hold, DONE
    // ignored in ADDR, ADDR_HS ignored in DATA.
    tbl[0]  = '{3'b001, 1'b0, 1'b0, 3'b001, 2'd0, 1'b1, 1'b1};
    tbl[1]  = '{3'b001, 1'b1, 1'b0, 3'b001, 2'd0, 1'b1, 1'b0};
    tbl[2]  = '{3'b000, 1'b0, 1'b1, 3'b000, 2'd0, 1'b0, 1'b0};
    tbl[3]  = '{3'b010, 1'b0, 1'b0, 3'b010, 2'd1, 1'b1, 1'b1};
    tbl[4]  = '{3'b000, 1'b1, 1'b1, 3'b000, 2'd1, 1'b0, 1'b0};
    tbl[5]  = '{3'b000, 1'b0, 1'b0, 3'b000, 2'd1, 1'b0, 1'b0};
    tbl[6]  = '{3'b011, 1'b0, 1'b0, 3'b001, 2'd0, 1'b1, 1'b1};
    tbl[7]  = '{3'b011, 1'b0, 1'b1, 3'b001, 2'd0, 1'b1, 1'b1};
    tbl[8]  = '{3'b000, 1'b1, 1'b0, 3'b001, 2'd0, 1'b1, 1'b0};
    tbl[9]  = '{3'b000, 1'b1, 1'b0, 3'b001, 2'd0, 1'b1, 1'b0};
    tbl[10] = '{3'b000, 1'b0, 1'b1, 3'b000, 2'd0, 1'b0, 1'b0};

    do_reset();
    for (int i = 0; i < 11; i++) begin
      step($sformatf("vec%0d", i), tbl[i].req, tbl[i].hs, tbl[i].done);
      chk($sformatf("vec%0d.grant", i), int'(GRANT),     int'(tbl[i].grant));
      chk($sformatf("vec%0d.idx", i),   int'(GRANT_IDX), int'(tbl[i].idx));
      chk($sformatf("vec%0d.busy", i),  int'(BUSY),      int'(tbl[i].busy));
      chk($sformatf("vec%0d.pend", i),  int'(ADDR_PEND), int'(tbl[i].pend));
    end

    // All masters requesting: order 0,1,2,0 with one idle cycle between grants.
    do_reset();
    for (int g = 0; g < 4; g++) begin
      step("rr.grant", 3'b111, 1'b0, 1'b0);
      chk($sformatf("rr.order%0d", g), int'(GRANT), 1 << (g % N));
      step("rr.hs", 3'b111, 1'b1, 1'b0);
      step("rr.done", 3'b111, 1'b0, 1'b1);
      chk($sformatf("rr.gap%0d", g), int'(GRANT), 0);
    end

    // Lock: master 1 in DATA keeps the grant while REQ moves to 101.
    do_reset();
    step("lock.g", 3'b010, 1'b0, 1'b0);
    step("lock.hs", 3'b010, 1'b1, 1'b0);
    step("lock.a", 3'b101, 1'b0, 1'b0);
    chk("lock.hold_a", int'(GRANT), 3'b010);
    step("lock.b", 3'b101, 1'b1, 1'b0);
    chk("lock.hold_b", int'(GRANT), 3'b010);
    step("lock.done", 3'b101, 1'b0, 1'b1);
    chk("lock.clear", int'(GRANT), 0);
    step("lock.next", 3'b101, 1'b0, 1'b0);
    chk("lock.next_m2", int'(GRANT), 3'b100);

    // Asynchronous reset mid-DATA clears outputs without a clock edge.
    do_reset();
    step("arst.g", 3'b100, 1'b0, 1'b0);
    step("arst.hs", 3'b100, 1'b1, 1'b0);
    chk("arst.pre", int'(GRANT), 3'b100);
    #1 ARESETn = 1'b0;
    #1;
    model_reset();
    chk_model("arst.now");
    @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    step("arst.regrant", 3'b100, 1'b0, 1'b0);
    chk("arst.regrant_m2", int'(GRANT), 3'b100);

    // Random traffic: a master holds its request until its transaction
    // finishes (occasionally giving up), so starvation can be bounded.
    do_reset();
    rq = '0;
    for (int m = 0; m < N; m++) waitc[m] = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int m = 0; m < N; m++) begin
        if (!rq[m] && ($urandom_range(3) == 0)) begin
          rq[m]    = 1'b1;
          waitc[m] = 0;
        end else if (rq[m] && m_owner != m && ($urandom_range(19) == 0)) begin
          rq[m]    = 1'b0;
          waitc[m] = 0;
        end
      end
      prev_owner = m_owner;
      step("rand", rq, 1'($urandom_range(1)), 1'($urandom_range(2) == 0));
      if (prev_owner < 0 && m_owner >= 0) begin
        for (int m = 0; m < N; m++) begin
          if (m == m_owner) begin
            waitc[m] = 0;
          end else if (rq[m]) begin
            waitc[m]++;
            chk($sformatf("starve.m%0d", m), (waitc[m] < N) ? 1 : 0, 1);
          end
        end
      end
      if (prev_owner >= 0 && m_owner < 0) begin
        rq[prev_owner] = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

`default_nettype wire
